// File: rtl/quota_stream.sv
// Multi-channel quota converter: latches CH signed samples, streams BITSTREAM beats of stochastic bits.
// Define QUOTA_STREAM_BITREV_EN to spread ones by bit-reversing the beat position.
module quota_lane #(
   parameter int QUANT = 8,
   parameter int L     = 6
) (
   input  logic [QUANT-1:0] data,
   input  logic [L-1:0]     pos,
   input  logic [L:0]       quota,
   output logic [L:0]       q,
   output logic             hit
);
   localparam int S = QUANT - L;
   localparam logic [QUANT-1:0] MSB = QUANT'(1) << (QUANT - 1);
   localparam logic [QUANT:0]   RND = (S > 0) ? ((QUANT+1)'(1) << ((S > 0) ? S - 1 : 0)) : '0;

   logic [QUANT:0] bias;
   logic [QUANT:0] rnd_sum;

   // offset binary keeps the quota monotonic across the signed range
   assign bias    = {1'b0, data ^ MSB};
   assign rnd_sum = bias + RND;
   assign q       = (L+1)'(rnd_sum >> S);
   assign hit     = {1'b0, pos} < quota;
endmodule

module quota_stream #(
   parameter int CH        = 4,
   parameter int BITSTREAM = 64,
   parameter int QUANT     = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [CH*QUANT-1:0]                  in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [CH-1:0]                        out_bits,
   output logic                                 out_last,
   output logic [CH*($clog2(BITSTREAM)+1)-1:0]  quota
);
   localparam int L  = $clog2(BITSTREAM);
   localparam int QW = L + 1;
   localparam logic [L-1:0] LAST = L'(BITSTREAM - 1);

   generate
      if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bs
         $error("quota_stream: BITSTREAM must be a power of 2 and >= 2");
      end
      if (QUANT < L) begin : g_bad_quant
         $error("quota_stream: QUANT must be >= clog2(BITSTREAM)");
      end
   endgenerate

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                 state, state_nxt;
   logic [L-1:0]           cnt, cnt_nxt, pos;
   logic [CH-1:0][QW-1:0]  q_reg, q_new;
   logic [CH-1:0]          hit;
   logic                   load;

`ifdef QUOTA_STREAM_BITREV_EN
   for (genvar i = 0; i < L; i++) begin : g_rev
      assign pos[i] = cnt[L-1-i];
   end
`else
   assign pos = cnt;
`endif

   for (genvar c = 0; c < CH; c++) begin : g_lane
      quota_lane #(.QUANT(QUANT), .L(L)) u_lane (
         .data  (in_data[c*QUANT +: QUANT]),
         .pos   (pos),
         .quota (q_reg[c]),
         .q     (q_new[c]),
         .hit   (hit[c])
      );
   end

   assign quota    = q_reg;
   assign out_bits = hit & {CH{state == STREAM}};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               cnt_nxt   = '0;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            out_last  = (cnt == LAST);
            if (out_ready) begin
               if (out_last) begin
                  // last beat frees the input so a pending set follows with no bubble
                  in_ready = 1'b1;
                  cnt_nxt  = '0;
                  if (in_valid) load = 1'b1;
                  else          state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         q_reg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (load) q_reg <= q_new;
      end
   end
endmodule

// File: tb/tb_quota_stream.sv
// Scoreboard bench for quota_stream: expected beats queued at load, compared as beats are accepted.
module tb_quota_stream;
   localparam int CH    = 4;
   localparam int BS    = 64;
   localparam int QUANT = 8;
   localparam int L     = $clog2(BS);
   localparam int QW    = L + 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [CH*QUANT-1:0]  in_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [CH-1:0]        out_bits;
   logic                 out_last;
   logic [CH*QW-1:0]     quota;

   quota_stream #(.CH(CH), .BITSTREAM(BS), .QUANT(QUANT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .out_last  (out_last),
      .quota     (quota)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] bits;
      logic          last;
   } beat_t;

   beat_t             sb[$];
   logic [CH*QW-1:0]  qsb[$];
   int                n_chk = 0;
   int                n_err = 0;
   bit                abort = 1'b0;
   int                sbeats = 0;
   int                ones[CH];
   bit                stalled = 1'b0;
   beat_t             held;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int mq(int d);
      int s, b;
      s = QUANT - L;
      b = d + (1 << (QUANT - 1));
      if (s > 0) return (b + (1 << (s - 1))) >> s;
      return b;
   endfunction

   function automatic int mpos(int k);
`ifdef QUOTA_STREAM_BITREV_EN
      int r;
      r = 0;
      for (int i = 0; i < L; i++) r |= ((k >> i) & 1) << (L - 1 - i);
      return r;
`else
      return k;
`endif
   endfunction

   task automatic load(input int d0, input int d1, input int d2, input int d3);
      int d[CH];
      logic [CH*QW-1:0] qv;
      int n;
      beat_t b;
      d = '{d0, d1, d2, d3};
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
         in_data[c*QUANT +: QUANT] = QUANT'(d[c]);
         qv[c*QW +: QW] = QW'(mq(d[c]));
      end
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("load_timeout", 64'(n < 500), 1);
      if (out_valid) check("b2b_last", out_last, 1);
      @(posedge clk);
      for (int k = 0; k < BS; k++) begin
         b.last = (k == BS - 1);
         for (int c = 0; c < CH; c++) b.bits[c] = (mpos(k) < mq(d[c]));
         sb.push_back(b);
      end
      qsb.push_back(qv);
      #1;
      in_valid = 1'b0;
      in_data  = (CH*QUANT)'($urandom());
      @(negedge clk);
      check("valid_after_load", out_valid, 1);
      check("quota", quota, qv);
   endtask

   task automatic drain(input bit stall);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 5000) begin
         @(posedge clk);
         #1 out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         n++;
      end
      check("drain_timeout", 64'(n < 5000), 1);
      out_ready = 1'b1;
   endtask

   task automatic idle_check();
      @(negedge clk);
      check("idle_valid", out_valid, 0);
      check("idle_bits", out_bits, 0);
      check("idle_last", out_last, 0);
      check("idle_ready", in_ready, 1);
   endtask

   always @(negedge clk) begin
      beat_t e;
      logic [CH*QW-1:0] qv;
      if (!rst_n || abort) begin
         stalled = 1'b0;
      end else begin
         if (stalled && out_valid) begin
            check("stall_bits", out_bits, held.bits);
            check("stall_last", out_last, held.last);
         end
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = sb.pop_front();
               check("bits", out_bits, e.bits);
               check("last", out_last, e.last);
               sbeats++;
               for (int c = 0; c < CH; c++) ones[c] += int'(out_bits[c]);
               if (e.last) begin
                  qv = qsb.pop_front();
                  check("beats", sbeats, BS);
                  for (int c = 0; c < CH; c++) begin
                     check("ones", ones[c], qv[c*QW +: QW]);
                     ones[c] = 0;
                  end
                  sbeats = 0;
               end
            end
         end else if (out_valid) begin
            stalled   = 1'b1;
            held.bits = out_bits;
            held.last = out_last;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int c = 0; c < CH; c++) ones[c] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_bits", out_bits, 0);
      check("rst_last", out_last, 0);
      check("rst_quota", quota, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", in_ready, 1);
      out_ready = 1'b1;

      // extremes, then rounding, then the extremes again under backpressure
      load(-128, 0, 127, -3);
      drain(1'b0);
      idle_check();
      load(1, 2, -2, -128);
      drain(1'b0);
      idle_check();
      load(-128, 0, 127, -3);
      drain(1'b1);
      idle_check();

      // back-to-back: second set pending while first stream runs
      out_ready = 1'b1;
      load(-3, 127, 0, 1);
      load(2, -2, -128, 127);
      drain(1'b0);
      idle_check();

      repeat (2) begin
         load(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
         drain(1'b1);
      end
      idle_check();

      // reset in the middle of a stream
      out_ready = 1'b1;
      load(0, 1, 2, 3);
      n = 0;
      while (sbeats < 20 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_timeout", 64'(n < 200), 1);
      abort = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mid_valid", out_valid, 0);
      check("mid_quota", quota, 0);
      check("mid_ready", in_ready, 1);
      check("mid_last", out_last, 0);
      sb.delete();
      qsb.delete();
      sbeats = 0;
      for (int c = 0; c < CH; c++) ones[c] = 0;
      abort = 1'b0;
      load(5, -5, 60, -60);
      drain(1'b0);
      idle_check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/quota_stream.md
Name: quota_stream

Overview:
- Multi-channel successor to the single-channel quota converter.
- Latches CH signed QUANT-bit samples, converts each to a rounded ones-count (quota) for a BITSTREAM-long stochastic stream, then emits the streams serially, one bit per channel per beat.
- Ready/valid on both sides.
- Sits between the quantised activation path and the stochastic compute array.

Parameters:
- CH, 4: number of parallel channels.
- BITSTREAM, 64: stream length in beats; must be a power of 2, >= 2 (elaboration $error otherwise).
- QUANT, 8: input sample width, two's complement; must satisfy QUANT >= $clog2(BITSTREAM) (elaboration $error otherwise).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_data holds a valid sample set.
- in_ready  output  1  block can accept a sample set.
- in_data  input  CH*QUANT  channel c occupies bits [c*QUANT +: QUANT], signed.
- out_valid  output  1  out_bits holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_bits  output  CH  one stochastic bit per channel for the current beat.
- out_last  output  1  high on beat BITSTREAM-1 of a stream.
- quota  output  CH*($clog2(BITSTREAM)+1)  latched quota per channel, stable for the whole stream.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is synchronous and active-low.
- Definitions: L = $clog2(BITSTREAM); S = QUANT - L.
- Quota arithmetic per channel, in QUANT+1 bits:
  - bias = data with MSB inverted, zero-extended (offset binary, range 0..2^QUANT-1).
  - round = bias + (S > 0 ? 2^(S-1) : 0).
  - q = round >> S. Range is 0..BITSTREAM, so no saturation is needed.
  - Computed combinationally from in_data and registered on input handshake.
- States: IDLE, STREAM.
- Reset (rst_n=0 at clk edge), regardless of state:
  - state=IDLE, beat counter cnt=0.
  - quota=0, out_valid=0, out_last=0, out_bits=0.
  - in_ready=1 from the first cycle after reset release.
- IDLE:
  - in_ready=1, out_valid=0, out_bits=0.
  - When in_valid & in_ready: latch all CH quotas, cnt<=0, go to STREAM.
  - Latency: first beat valid on the cycle after the input handshake.
- STREAM:
  - out_valid=1.
  - out_bits[c] = (pos < quota[c]), where pos = cnt by default.
  - out_last = (cnt == BITSTREAM-1).
  - Beat handshake (out_valid & out_ready) advances cnt by 1.
  - With out_ready=0, cnt, out_bits and out_last hold stable (no beat lost or duplicated).
- Last beat: handshake when cnt == BITSTREAM-1.
  - in_ready=1 in this same cycle (combinational: STREAM & out_last & out_ready).
  - If in_valid is also high: new quotas latched, cnt<=0, stay in STREAM (back-to-back, no bubble).
  - Otherwise: go to IDLE.
- in_ready=0 on all other STREAM cycles; in_data is ignored then.
- Counter: cnt is L bits. Wrap from BITSTREAM-1 occurs only via the last-beat rule.
- Ones per stream on channel c equals quota[c] exactly (0 gives all zeros, BITSTREAM gives all ones).
- Reset mid-stream: stream is aborted and no out_last is issued; the next stream restarts at cnt=0.

Optional Feature:
- Macro: QUOTA_STREAM_BITREV_EN.
- Defined: pos = bit-reverse of cnt over L bits. Ones are spread evenly across the stream, which lowers correlation between streams. The count of ones is unchanged.
- Undefined: pos = cnt. Thermometer code: all ones first, then zeros.
- No port or timing difference between the two builds.

Test Plan:
- Thermometer extremes: CH=4, BITSTREAM=64, QUANT=8, in_data = {-128, 0, 127, -3}.
  - Required quota = {0, 32, 64, 31}.
  - Ch0 all 0; ch1 beats 0-31 =1, 32-63 =0; ch2 all 1; ch3 beats 0-30 =1.
  - out_last only on beat 63.
- Rounding: data = 1 -> 32; data = 2 -> 33; data = -2 -> 32 (bias 126+2=128>>2).
  - In every case, ones counted over 64 beats equal quota.
- Backpressure: toggle out_ready randomly (~50%) through a stream.
  - Exactly 64 accepted beats; pattern identical to the no-stall run.
  - out_bits and out_last stable while stalled.
- Back-to-back: hold in_valid=1 with a new set pending during beat 63 with out_ready=1.
  - in_ready=1 that cycle; next cycle is beat 0 of the new stream.
  - Zero idle cycles between streams.
- Reset mid-stream: assert rst_n=0 for one cycle at beat 20.
  - Next cycle: out_valid=0, quota=0, in_ready=1.
  - A new load restarts at cnt=0.
- With QUOTA_STREAM_BITREV_EN: data = 0 (quota 32) gives alternating 1,0,1,0,... from beat 0.
  - quota 16 gives ones at beats 0, 4, 8, ..., 60.
  - Ones count is unchanged versus the thermometer build.
